mips_pc_ir_unit: RTL and testbench

- Sequential datapath slice of the multicycle MIPS core, directly downstream of the multicycle control FSM.
- Holds PC, IR, MDR and ALUOut, drives the memory address, selects and applies the next PC, and decodes IR fields.
- Feeds op_code back upstream to the control FSM.
- Carries retired-instruction and cycle counters for lab debug.

---
 rtl/mips_pc_ir_unit_pkg.sv | 29 ++
 rtl/mips_wrap_counter.sv | 24 ++
 rtl/mips_pc_ir_unit.sv | 110 +++++++++++
 tb/tb_mips_pc_ir_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mips_pc_ir_unit_pkg.sv
// Shared constants for the multicycle MIPS PC/IR datapath slice.
//   - next-PC source encodings (PCSource)
//   - instruction register field bit positions
//   - jump target helper
package mips_pc_ir_unit_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  // J-type target: upper PC nibble, 26-bit index, word aligned (32-bit datapath).
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [31:0] ir);
    return {pc[31:28], ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mips_wrap_counter.sv
// Free-running enabled counter with synchronous reset; wraps silently.
//   clk   : clock
//   rst   : synchronous active-high reset, clears count to 0
//   en    : increment enable
//   count : current value
module mips_wrap_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)     r_count <= '0;
    else if (en) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/mips_pc_ir_unit.sv
// PC / IR / MDR / ALUOut datapath slice of the multicycle MIPS core.
// Selects and applies the next PC, drives the memory address, decodes IR
// fields for the control FSM and keeps debug counters.
//   Inputs : clk, rst, PCWrite, PCWriteCond, IorD, IRWrite, PCSource[1:0],
//            zero, alu_result[WIDTH], mem_rdata[WIDTH]
//   Outputs: mem_addr, pc, ir, mdr, alu_out [WIDTH]; op_code, rs, rt, rd,
//            funct, imm16 (IR slices); instr_count, cycle_count [CNT_W];
//            pc_src_err (sticky reserved-PCSource flag)
module mips_pc_ir_unit
  import mips_pc_ir_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [1:0]       PCSource,
  input  logic             zero,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] alu_out,
  output logic [5:0]       op_code,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             pc_src_err
);

  logic [WIDTH-1:0] r_pc, r_ir, r_mdr, r_alu_out;
  logic             r_pc_src_err;

  logic             w_pc_en;
  logic             w_rsvd;
  logic [WIDTH-1:0] w_pc_next;

  assign w_pc_en = PCWrite | (PCWriteCond & zero);
  assign w_rsvd  = (PCSource == PCSRC_RSVD);

  // Jump target is built from pre-edge pc/ir, so a jump that coincides with
  // IRWrite still uses the instruction currently held in IR.
  always_comb begin
    w_pc_next = r_pc;
    unique case (PCSource)
      PCSRC_ALU:    w_pc_next = alu_result;
      PCSRC_ALUOUT: w_pc_next = r_alu_out;
      PCSRC_JUMP:   w_pc_next = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
      default:      w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_mdr        <= '0;
      r_alu_out    <= '0;
      r_pc_src_err <= 1'b0;
    end else begin
      r_mdr     <= mem_rdata;
      r_alu_out <= alu_result;
      if (IRWrite) r_ir <= mem_rdata;
      if (w_pc_en) begin
        if (w_rsvd) r_pc_src_err <= 1'b1;
        else        r_pc         <= w_pc_next;
      end
    end
  end

  mips_wrap_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (IRWrite),
    .count (instr_count)
  );

  mips_wrap_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (cycle_count)
  );

  assign mem_addr   = IorD ? r_alu_out : r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign mdr        = r_mdr;
  assign alu_out    = r_alu_out;
  assign pc_src_err = r_pc_src_err;

  assign op_code = r_ir[OP_HI:OP_LO];
  assign rs      = r_ir[RS_HI:RS_LO];
  assign rt      = r_ir[RT_HI:RT_LO];
  assign rd      = r_ir[RD_HI:RD_LO];
  assign funct   = r_ir[FUNCT_HI:FUNCT_LO];
  assign imm16   = r_ir[15:0];

endmodule

// File: tb/tb_mips_pc_ir_unit.sv
// Directed bench for mips_pc_ir_unit (CNT_W=4 so counter wrap is reachable).
module tb_mips_pc_ir_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, PCWrite, PCWriteCond, IorD, IRWrite, zero;
  logic [1:0]       PCSource;
  logic [WIDTH-1:0] alu_result, mem_rdata;
  logic [WIDTH-1:0] mem_addr, pc, ir, mdr, alu_out;
  logic [5:0]       op_code, funct;
  logic [4:0]       rs, rt, rd;
  logic [15:0]      imm16;
  logic [CNT_W-1:0] instr_count, cycle_count;
  logic             pc_src_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_pc_ir_unit #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .IRWrite(IRWrite), .PCSource(PCSource), .zero(zero),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .pc(pc), .ir(ir), .mdr(mdr), .alu_out(alu_out), .op_code(op_code),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16),
    .instr_count(instr_count), .cycle_count(cycle_count),
    .pc_src_err(pc_src_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    PCWrite = 0; PCWriteCond = 0; IorD = 0; IRWrite = 0; zero = 0;
    PCSource = 2'b00;
  endtask

  initial begin
    rst = 1; idle_ctl();
    PCWrite = 1; alu_result = 32'h0000_0004; mem_rdata = 32'hDEAD_BEEF;
    repeat (3) step();
    chk("rst_pc",     pc, 32'h0);
    chk("rst_ir",     ir, 32'h0);
    chk("rst_mdr",    mdr, 32'h0);
    chk("rst_aluout", alu_out, 32'h0);
    chk("rst_icnt",   32'(instr_count), 32'h0);
    chk("rst_ccnt",   32'(cycle_count), 32'h0);
    chk("rst_err",    32'(pc_src_err), 32'h0);
    chk("rst_maddr",  mem_addr, 32'h0);

    // Fetch
    rst = 0; mem_rdata = 32'h012A_4020; IRWrite = 1; PCWrite = 1;
    PCSource = 2'b00; alu_result = 32'h4;
    step();
    chk("f_pc",    pc, 32'h4);
    chk("f_ir",    ir, 32'h012A_4020);
    chk("f_op",    32'(op_code), 32'h0);
    chk("f_rs",    32'(rs), 32'd9);
    chk("f_rt",    32'(rt), 32'd10);
    chk("f_rd",    32'(rd), 32'd8);
    chk("f_funct", 32'(funct), 32'h20);
    chk("f_imm",   32'(imm16), 32'h4020);
    chk("f_mdr",   mdr, 32'h012A_4020);
    chk("f_icnt",  32'(instr_count), 32'd1);
    chk("f_ccnt",  32'(cycle_count), 32'd1);

    // Branch: load ALUOut=0x40, then conditional write not taken / taken
    idle_ctl(); alu_result = 32'h40; mem_rdata = 32'h1111_2222;
    step();
    chk("b_aluout", alu_out, 32'h40);
    chk("b_ir_hold", ir, 32'h012A_4020);
    PCWriteCond = 1; zero = 0; PCSource = 2'b01;
    step();
    chk("b_nt_pc", pc, 32'h4);
    zero = 1;
    step();
    chk("b_t_pc",  pc, 32'h40);
    chk("b_maddr", mem_addr, 32'h40);
    chk("b_ccnt",  32'(cycle_count), 32'd4);

    // Jump setup: pc=0x1000_0000, ir=0x0800_0010
    idle_ctl(); PCWrite = 1; IRWrite = 1;
    alu_result = 32'h1000_0000; mem_rdata = 32'h0800_0010;
    step();
    chk("j_setpc", pc, 32'h1000_0000);
    chk("j_op",    32'(op_code), 32'h2);
    // Jump with simultaneous IRWrite: target uses old ir
    PCSource = 2'b10; mem_rdata = 32'hFFFF_FFFF; alu_result = 32'h2000;
    step();
    chk("j_pc",   pc, 32'h1000_0040);
    chk("j_ir",   ir, 32'hFFFF_FFFF);
    chk("j_icnt", 32'(instr_count), 32'd3);
    idle_ctl(); IorD = 1;
    #1;
    chk("j_maddr_aluout", mem_addr, 32'h2000);
    IorD = 0;
    #1;
    chk("j_maddr_pc", mem_addr, 32'h1000_0040);

    // Reserved PCSource
    PCWrite = 1; PCSource = 2'b11; alu_result = 32'h5555;
    step();
    chk("r_pc_hold", pc, 32'h1000_0040);
    chk("r_err",     32'(pc_src_err), 32'h1);
    idle_ctl();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r_err_sticky", 32'(pc_src_err), 32'h1);
    end
    rst = 1;
    step();
    chk("r_err_clr",  32'(pc_src_err), 32'h0);
    chk("r_rst_pc",   pc, 32'h0);
    chk("r_rst_icnt", 32'(instr_count), 32'h0);

    // Counter wrap: 16 IRWrite pulses
    rst = 0; IRWrite = 1;
    for (int i = 0; i < 16; i++) begin
      mem_rdata = 32'(i);
      step();
      chk("w_icnt", 32'(instr_count), 32'((i + 1) % 16));
    end
    chk("w_icnt_zero", 32'(instr_count), 32'h0);
    chk("w_ccnt_zero", 32'(cycle_count), 32'h0);

    // Reset mid-sequence with enables active
    repeat (5) step();
    chk("m_icnt_pre", 32'(instr_count), 32'd5);
    rst = 1; PCWrite = 1; alu_result = 32'h88; mem_rdata = 32'hABCD_0000;
    step();
    chk("m_icnt", 32'(instr_count), 32'h0);
    chk("m_ccnt", 32'(cycle_count), 32'h0);
    chk("m_pc",   pc, 32'h0);
    chk("m_ir",   ir, 32'h0);
    chk("m_mdr",  mdr, 32'h0);
    rst = 0;
    step();
    chk("m_post_icnt", 32'(instr_count), 32'd1);
    chk("m_post_ccnt", 32'(cycle_count), 32'd1);
    chk("m_post_pc",   pc, 32'h88);
    chk("m_post_ir",   ir, 32'hABCD_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
